// File: rtl/mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter
//
// Round-robin arbiter that shares one 2:1 mux datapath between two burst
// requesters and forwards the selected beat to a single valid/ready sink.
// A grant is held for a whole burst. It is released when a beat flagged
// "last" is accepted. When the other requester is waiting, ownership passes
// straight to it with no idle cycle. This block is the only driver of the
// downstream mux select.
//
// Parameters
//   WIDTH      data width of both requesters and of out_data
//   BURST_MAX  maximum accepted beats per grant. It is only used when
//              MUX_ARB_BURST_CAP_EN is defined.
//
// Optional feature
//   MUX_ARB_BURST_CAP_EN  When defined, a grant is also released once
//                         BURST_MAX beats have been accepted, even without
//                         "last". The requester then re-arbitrates for the
//                         remainder of its burst. When undefined, no beat
//                         counter is built.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   req0/1     in   requester has a beat presented
//   data0/1    in   requester beat data
//   last0/1    in   beat is the final beat of the requester's burst
//   out_ready  in   downstream accepts a beat this cycle
//   out_valid  out  beat present on out_data (combinational)
//   out_data   out  muxed data: data1 when sel=1, else data0
//   gnt0/1     out  requester owns the mux (registered)
//   sel        out  mux select, equal to gnt1 (registered)
// ---------------------------------------------------------------------------
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             last0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             last1,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_served_q, last_served_d;
  logic   gnt0_q, gnt1_q, sel_q;
  logic   acc0, acc1;
  logic   cap_hit;

  // A beat transfers only while its requester owns the mux and the sink is ready.
  assign acc0 = (state_q == G0) & req0 & out_ready;
  assign acc1 = (state_q == G1) & req1 & out_ready;

  assign out_valid = ((state_q == G0) & req0) | ((state_q == G1) & req1);
  assign out_data  = sel_q ? data1 : data0;

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign sel  = sel_q;

`ifdef MUX_ARB_BURST_CAP_EN
  // The counter holds 0..BURST_MAX. It is cleared whenever ownership changes,
  // so it never needs to wrap.
  localparam int CNT_W = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(BURST_MAX - 1);

  logic [CNT_W-1:0] cnt_q;

  // True on the beat that would become the BURST_MAX-th accepted beat.
  assign cap_hit = (cnt_q == CAP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (acc0 | acc1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  assign cap_hit = 1'b0;

  // BURST_MAX has no function without the burst cap.
  logic unused_burst_max;
  assign unused_burst_max = (BURST_MAX > 0);
`endif

  // Next-state logic. On a tie, the requester that was not served last wins.
  // At the end of a burst, ownership passes directly to the other requester
  // if it is waiting.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_served_q)) begin
          state_d = G0;
        end else if (req1) begin
          state_d = G1;
        end
      end
      G0: begin
        if (acc0 && (last0 || cap_hit)) begin
          last_served_d = 1'b0;
          state_d       = req1 ? G1 : IDLE;
        end
      end
      G1: begin
        if (acc1 && (last1 || cap_hit)) begin
          last_served_d = 1'b1;
          state_d       = req0 ? G0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered grant/select outputs. Reset aborts any burst
  // in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      sel_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      gnt0_q        <= (state_d == G0);
      gnt1_q        <= (state_d == G1);
      sel_q         <= (state_d == G1);
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux2_rr_arbiter
//
// Directed scenarios followed by randomized traffic. The expected behaviour
// comes from a small ownership model: an owner index, the index of the
// requester served last, and a beat count.
// ---------------------------------------------------------------------------
module tb_mux2_rr_arbiter;
  localparam int WIDTH     = 8;
  localparam int BURST_MAX = 4;
`ifdef MUX_ARB_BURST_CAP_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             req0, req1, last0, last1, out_ready;
  logic [WIDTH-1:0] data0, data1;
  logic             out_valid, gnt0, gnt1, sel;
  logic [WIDTH-1:0] out_data;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .BURST_MAX(BURST_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .data0     (data0),
    .last0     (last0),
    .req1      (req1),
    .data1     (data1),
    .last1     (last1),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: -1 = nobody owns the mux
  int m_owner = -1;
  int m_last  = 1;
  int m_cnt   = 0;
  int m_acc   = 0;
  int obs_acc  = 0;
  int obs_acc1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit exp_valid;
    exp_valid = 1'b0;
    if (m_owner == 0) exp_valid = req0;
    if (m_owner == 1) exp_valid = req1;
    chk("m_gnt0", {31'd0, gnt0}, {31'd0, m_owner == 0});
    chk("m_gnt1", {31'd0, gnt1}, {31'd0, m_owner == 1});
    chk("m_sel", {31'd0, sel}, {31'd0, m_owner == 1});
    chk("m_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    if (m_owner >= 0)
      chk("m_data", {24'd0, out_data}, {24'd0, (m_owner == 1) ? data1 : data0});
  endtask

  task automatic model_step(input bit s_rst, input bit r0, input bit r1,
                            input bit l0, input bit l1, input bit rdy);
    bit r[2];
    bit l[2];
    bit acc;
    r[0] = r0; r[1] = r1; l[0] = l0; l[1] = l1;
    if (s_rst) begin
      m_owner = -1;
      m_last  = 1;
      m_cnt   = 0;
    end else begin
      acc = 1'b0;
      if (m_owner >= 0) acc = r[m_owner] && rdy;
      if (acc) m_acc++;
      if (m_owner < 0) begin
        if (r[0] && r[1]) m_owner = 1 - m_last;
        else if (r[0])    m_owner = 0;
        else if (r[1])    m_owner = 1;
        m_cnt = 0;
      end else if (acc && (l[m_owner] || (CAP && (m_cnt + 1 == BURST_MAX)))) begin
        m_last  = m_owner;
        m_owner = r[1 - m_last] ? (1 - m_last) : -1;
        m_cnt   = 0;
      end else if (acc) begin
        m_cnt++;
      end
    end
  endtask

  // One clock: check outputs mid-cycle, clock the DUT and the model on the
  // same edge using the inputs held through that edge, and return at negedge.
  task automatic cyc(input bit do_chk);
    bit s_rst, s_r0, s_r1, s_l0, s_l1, s_rdy;
    #1;
    if (do_chk) begin
      check_model();
      if (!rst && out_valid && out_ready) begin
        obs_acc++;
        if (sel) obs_acc1++;
      end
    end
    s_rst = rst; s_r0 = req0; s_r1 = req1; s_l0 = last0; s_l1 = last1; s_rdy = out_ready;
    @(posedge clk);
    model_step(s_rst, s_r0, s_r1, s_l0, s_l1, s_rdy);
    @(negedge clk);
  endtask

  initial begin
    int  n0;
    int  acc1_base;
    bit  hold0, hold1;

    // Reset held for 2 cycles with both requesters asking
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; last0 = 1'b0; last1 = 1'b0;
    data0 = '0; data1 = '0; out_ready = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst_sel", {31'd0, sel}, 32'd0);
    #1 chk("rst_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    cyc(1'b1);
    chk("rel_gnt0", {31'd0, gnt0}, 32'd1);

    // Single-beat burst from ch0
    data0 = 8'hA5; last0 = 1'b1; req1 = 1'b0; out_ready = 1'b1;
    #1;
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", {24'd0, out_data}, 32'h0000_00A5);
    cyc(1'b1);
    chk("single_idle_gnt0", {31'd0, gnt0}, 32'd0);
    #1 chk("single_idle_valid", {31'd0, out_valid}, 32'd0);

    // Both requesting, every beat last: strict alternation starting with ch1
    req0 = 1'b1; req1 = 1'b1; last0 = 1'b1; last1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data0 = 8'(8'h10 + i); data1 = 8'(8'h80 + i);
      cyc(1'b1);
      chk("alt_sel", {31'd0, sel}, {31'd0, (i % 2) == 0});
      chk("alt_nogap", {31'd0, gnt0 ^ gnt1}, 32'd1);
    end
    req1 = 1'b0;
    cyc(1'b1);

    // ch1 burst of 3 with a 2-cycle stall while ch0 waits
    req0 = 1'b1; req1 = 1'b1; last0 = 1'b0; last1 = 1'b0; out_ready = 1'b1;
    data1 = 8'h11;
    cyc(1'b1);
    acc1_base = obs_acc1;
    cyc(1'b1);
    data1 = 8'h22; out_ready = 1'b0;
    cyc(1'b1);
    chk("stall_gnt1_a", {31'd0, gnt1}, 32'd1);
    cyc(1'b1);
    chk("stall_gnt1_b", {31'd0, gnt1}, 32'd1);
    out_ready = 1'b1;
    cyc(1'b1);
    data1 = 8'h33; last1 = 1'b1;
    cyc(1'b1);
    chk("stall_beats", 32'(obs_acc1 - acc1_base), 32'd3);
    chk("stall_gnt0_next", {31'd0, gnt0}, 32'd1);

    // Reset in G0 after beat 1 of 3
    last0 = 1'b1; req1 = 1'b0;
    cyc(1'b1);
    last0 = 1'b0;
    cyc(1'b1);
    data0 = 8'h01;
    cyc(1'b1);
    rst = 1'b1; data0 = 8'h02;
    cyc(1'b1);
    chk("midrst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("midrst_gnt1", {31'd0, gnt1}, 32'd0);
    rst = 1'b0; req1 = 1'b1;
    cyc(1'b1);
    chk("midrst_tie_gnt0", {31'd0, gnt0}, 32'd1);

    // 6-beat ch0 burst with ch1 waiting
    n0 = 0;
    last1 = 1'b1;
    for (int b = 0; b < 6; b++) begin
      data0 = 8'(8'hC0 + b); last0 = (b == 5);
      cyc(1'b1);
      n0++;
      if (gnt1) break;
    end
    chk("cap_beats", 32'(n0), CAP ? 32'd4 : 32'd6);

    // Randomized traffic obeying the hold-while-not-accepted rule
    hold0 = 1'b0; hold1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!hold0) begin
        req0  = ($urandom_range(0, 2) != 0);
        data0 = 8'($urandom);
        last0 = ($urandom_range(0, 2) == 0);
      end
      if (!hold1) begin
        req1  = ($urandom_range(0, 2) != 0);
        data1 = 8'($urandom);
        last1 = ($urandom_range(0, 2) == 0);
      end
      hold0 = req0 && !(m_owner == 0 && out_ready && !rst);
      hold1 = req1 && !(m_owner == 1 && out_ready && !rst);
      cyc(1'b1);
    end
    chk("acc_total", 32'(obs_acc), 32'(m_acc));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
